// File: rtl/dpram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dpram_arbiter_pkg
// Shared definitions for the dpram round-robin arbiter.
//   DEFAULT_*   : default configuration (4 clients, 1K x 8 RAM port)
//   tag_width() : width of a client index, clog2(REQUESTERS), never below 1
//   mem_cmd_t   : arbiter-to-RAM command record (wren, address, data) for the
//                 default geometry; the arbiter builds the same record from
//                 its own parameters so other geometries stay consistent.
// -----------------------------------------------------------------------------
package dpram_arbiter_pkg;

    localparam int DEFAULT_REQUESTERS    = 4;
    localparam int DEFAULT_ADDRESS_WIDTH = 10;
    localparam int DEFAULT_DATA_WIDTH    = 8;

    // Client index width. A 2-client arbiter still needs one bit of index.
    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_TAG_WIDTH = tag_width(DEFAULT_REQUESTERS);

    typedef struct packed {
        logic                             wren;
        logic [DEFAULT_ADDRESS_WIDTH-1:0] address;
        logic [DEFAULT_DATA_WIDTH-1:0]    data;
    } mem_cmd_t;

endpackage

// File: rtl/dpram_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin winner selection.
//   req       in  : pending request bits, one per client
//   last      in  : index of the most recent winner
//   grant     out : one-hot winner, zero when no request is pending
//   winner    out : binary index of the winner (0 when no request)
//   any_grant out : some client won this cycle
// The search starts at last+1 and wraps, so the previous winner has the
// lowest priority in the following cycle.
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int REQUESTERS = 4,
    parameter int TAG_WIDTH  = 2
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [TAG_WIDTH-1:0]  last,
    output logic [REQUESTERS-1:0] grant,
    output logic [TAG_WIDTH-1:0]  winner,
    output logic                  any_grant
);

    logic [TAG_WIDTH-1:0] cand;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int off = 1; off <= REQUESTERS; off++) begin
            cand = TAG_WIDTH'((int'(last) + off) % REQUESTERS);
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant[cand] = 1'b1;
                winner      = cand;
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_arbiter
// Shares one port of a dpram instance between REQUESTERS clients with a
// round-robin valid/ack handshake, one grant per cycle.
//   clk, reset_n        : clock (also clocks the RAM port), async active-low reset
//   req/we/addr/wdata   : per-client command, flattened client-major
//   ack                 : one-hot acceptance, combinational from req and last
//   rvalid/rdata        : one-cycle read return, two cycles after ack
//   mem_wren/address/data : registered command to the RAM port
//   mem_q               : registered RAM read data
// Timing: ack at t, command on mem_* at t+1, read data on mem_q at t+2.
// -----------------------------------------------------------------------------
module dpram_arbiter
    import dpram_arbiter_pkg::*;
#(
    parameter int REQUESTERS    = DEFAULT_REQUESTERS,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [REQUESTERS-1:0]            req,
    input  logic [REQUESTERS-1:0]            we,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] addr,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] wdata,
    output logic [REQUESTERS-1:0]            ack,
    output logic [REQUESTERS-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             mem_wren,
    output logic [ADDRESS_WIDTH-1:0]         mem_address,
    output logic [DATA_WIDTH-1:0]            mem_data,
    input  logic [DATA_WIDTH-1:0]            mem_q
);

    localparam int TAG_WIDTH = tag_width(REQUESTERS);

    // Same layout as the package record, sized by this instance's parameters.
    typedef struct packed {
        logic                     wren;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]    data;
    } cmd_t;

    // Tag travelling alongside the command so read data can be routed back.
    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] idx;
    } read_tag_t;

    // ---------------------------------------------------------------------
    // Unpack the flattened client buses
    // ---------------------------------------------------------------------
    logic [ADDRESS_WIDTH-1:0] addr_arr  [REQUESTERS];
    logic [DATA_WIDTH-1:0]    wdata_arr [REQUESTERS];

    generate
        for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign wdata_arr[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    logic [TAG_WIDTH-1:0]  last_reg, last_next;
    logic [REQUESTERS-1:0] grant;
    logic [TAG_WIDTH-1:0]  winner;
    logic                  any_grant;
    logic                  transfer;

    rr_picker #(
        .REQUESTERS (REQUESTERS),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_picker (
        .req       (req),
        .last      (last_reg),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant)
    );

    // While reset is held nothing may be accepted: a client seeing ack would
    // drop its command even though the command register is being cleared.
    assign ack      = grant & {REQUESTERS{reset_n}};
    assign transfer = any_grant & reset_n;

    // ---------------------------------------------------------------------
    // Command stage and read-return pipeline
    // ---------------------------------------------------------------------
    cmd_t                  cmd_reg, cmd_next;
    read_tag_t             tag_reg, tag_next;
    logic [REQUESTERS-1:0] rvalid_reg, rvalid_next;

    always_comb begin
        last_next     = last_reg;
        cmd_next      = cmd_reg;
        cmd_next.wren = 1'b0;          // idle cycles never repeat a write
        tag_next      = tag_reg;
        tag_next.valid = 1'b0;
        rvalid_next   = '0;

        if (transfer) begin
            last_next        = winner;
            cmd_next.wren    = we[winner];
            cmd_next.address = addr_arr[winner];
            cmd_next.data    = wdata_arr[winner];
            tag_next.valid   = ~we[winner];
            tag_next.idx     = winner;
        end

        // The tag was captured alongside the command; one cycle later the
        // RAM's output register holds the data for that command.
        if (tag_reg.valid) begin
            rvalid_next[tag_reg.idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_reg   <= TAG_WIDTH'(REQUESTERS - 1);
            cmd_reg    <= '0;
            tag_reg    <= '0;
            rvalid_reg <= '0;
        end else begin
            last_reg   <= last_next;
            cmd_reg    <= cmd_next;
            tag_reg    <= tag_next;
            rvalid_reg <= rvalid_next;
        end
    end

    assign mem_wren    = cmd_reg.wren;
    assign mem_address = cmd_reg.address;
    assign mem_data    = cmd_reg.data;
    assign rvalid      = rvalid_reg;
    assign rdata       = mem_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_arbiter
// Self-checking bench for dpram_arbiter with a behavioural single-port RAM
// (registered output) attached to the mem_* port. Per-client command queues
// feed the handshake; a scoreboard process predicts the grant from the
// round-robin rule and queues the expected RAM command, and a monitor process
// checks mem_* and the read return against a reference memory array.
// -----------------------------------------------------------------------------
module tb_dpram_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    ack;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_wren;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_data;
    logic [DW-1:0]   mem_q;

    always #5 clk = ~clk;

    dpram_arbiter #(
        .REQUESTERS    (N),
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .mem_wren    (mem_wren),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_q       (mem_q)
    );

    // Behavioural dpram port: registered output, write-through on writes.
    logic [DW-1:0] ram [1<<AW];
    always @(posedge clk) begin
        if (mem_wren) begin
            ram[mem_address] <= mem_data;
            mem_q            <= mem_data;
        end else begin
            mem_q <= ram[mem_address];
        end
    end

    // ---------------------------------------------------------------------
    // Bookkeeping
    // ---------------------------------------------------------------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        int            due;
        int            idx;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    cmd_t          cq [N][$];
    exp_t          cmd_q[$];
    exp_t          rd_q[$];
    logic [DW-1:0] ref_mem [1<<AW];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic [N-1:0]  acked;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 5) return 8'hA5;
        return DW'((a * 37 + 11) & 8'hFF);
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    // ---------------------------------------------------------------------
    // Driver: present queue heads, pop on an accepted handshake
    // ---------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            acked = ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acked[i] && cq[i].size() > 0) void'(cq[i].pop_front());
                if (cq[i].size() > 0) begin
                    req[i]             = 1'b1;
                    we[i]              = cq[i][0].we;
                    addr[i*AW +: AW]   = cq[i][0].addr;
                    wdata[i*DW +: DW]  = cq[i][0].data;
                end else begin
                    req[i] = 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Scoreboard: predict the grant, queue the expected RAM command
    // ---------------------------------------------------------------------
    int           ref_last = N - 1;
    int           sb_win;
    logic [N-1:0] sb_exp_ack;
    int           wait_cnt [N];

    initial begin
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("ack_in_reset", 32'(ack), 32'd0);
                ref_last = N - 1;
                for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            end else begin
                sb_win = -1;
                for (int k = 1; k <= N; k++) begin
                    if (sb_win < 0 && req[(ref_last + k) % N]) sb_win = (ref_last + k) % N;
                end
                sb_exp_ack = (sb_win >= 0) ? (N'(1) << sb_win) : '0;
                check("ack", 32'(ack), 32'(sb_exp_ack));
                for (int i = 0; i < N; i++) begin
                    if (req[i] && !ack[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                    if (req[i]) check("wait_bound", 32'(wait_cnt[i] < N), 32'd1);
                end
                if (sb_win >= 0) begin
                    ref_last = sb_win;
                    cmd_q.push_back('{due: cyc + 1, idx: sb_win, we: we[sb_win],
                                      addr: addr[sb_win*AW +: AW],
                                      data: wdata[sb_win*DW +: DW]});
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Monitor: RAM command one cycle after ack, read return one cycle later
    // ---------------------------------------------------------------------
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rvalid_in_reset", 32'(rvalid), 32'd0);
                check("mem_wren_in_reset", 32'(mem_wren), 32'd0);
                check("mem_address_in_reset", 32'(mem_address), 32'd0);
                check("mem_data_in_reset", 32'(mem_data), 32'd0);
                cmd_q.delete();
                rd_q.delete();
            end else begin
                if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                    mon_e = rd_q.pop_front();
                    check("rvalid", 32'(rvalid), 32'(N'(1) << mon_e.idx));
                    check("rdata", 32'(rdata), 32'(ref_mem[mon_e.addr]));
                    $display("cycle %0d read  client %0d addr 0x%03h data 0x%02h",
                             cyc, mon_e.idx, mon_e.addr, rdata);
                end else begin
                    check("rvalid_idle", 32'(rvalid), 32'd0);
                end
                if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
                    mon_e = cmd_q.pop_front();
                    check("mem_wren", 32'(mem_wren), 32'(mon_e.we));
                    check("mem_address", 32'(mem_address), 32'(mon_e.addr));
                    if (mon_e.we) begin
                        check("mem_data", 32'(mem_data), 32'(mon_e.data));
                        ref_mem[mon_e.addr] = mon_e.data;
                        $display("cycle %0d write client %0d addr 0x%03h data 0x%02h",
                                 cyc, mon_e.idx, mon_e.addr, mon_e.data);
                    end else begin
                        mon_e.due = cyc + 1;
                        rd_q.push_back(mon_e);
                    end
                end else begin
                    check("mem_wren_idle", 32'(mem_wren), 32'd0);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Sequencing helpers
    // ---------------------------------------------------------------------
    function automatic bit busy();
        for (int i = 0; i < N; i++) if (cq[i].size() > 0) return 1'b1;
        return (cmd_q.size() > 0) || (rd_q.size() > 0);
    endfunction

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy() && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        if (busy()) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: cycle %0d got busy expected idle within %0d cycles",
                     cyc, max_cycles);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.we   = 1'($urandom_range(0, 1));
        c.addr = AW'($urandom_range(0, 31));
        c.data = DW'($urandom);
        return c;
    endfunction

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            ram[a]     = init_val(a);
            ref_mem[a] = init_val(a);
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single read from client 2 of the preloaded location 0x05.
        cq[2].push_back('{we: 1'b0, addr: AW'(5), data: '0});
        wait_idle(50);

        // All four clients read back to back, starting from client 0.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                cq[i].push_back('{we: 1'b0, addr: AW'($urandom_range(0, 31)), data: '0});
        wait_idle(50);

        // Client 0 alone, then client 1 write immediately followed by client 0 read.
        cq[0].push_back('{we: 1'b0, addr: AW'(32), data: '0});
        wait_idle(50);
        cq[1].push_back('{we: 1'b1, addr: AW'(16), data: 8'h3C});
        cq[0].push_back('{we: 1'b0, addr: AW'(16), data: '0});
        wait_idle(50);

        // Client 3 alone with a continuous command stream.
        for (int r = 0; r < 10; r++) cq[3].push_back(rand_cmd());
        wait_idle(50);

        // Reset pulse one cycle after a read ack; all clients request across it.
        cq[1].push_back('{we: 1'b0, addr: AW'(7), data: '0});
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ack[1] && n < 20);
            if (!ack[1]) begin
                checks++;
                errors++;
                $display("FAIL ack_wait: cycle %0d got no ack[1] expected ack within 20 cycles", cyc);
            end
        end
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < N; i++) cq[i].push_back('{we: 1'b0, addr: AW'(40 + i), data: '0});
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_idle(50);

        // Saturation: every client always has a command pending.
        for (int r = 0; r < 12; r++)
            for (int i = 0; i < N; i++) cq[i].push_back(rand_cmd());
        wait_idle(200);

        // Random traffic with idle gaps and address collisions.
        repeat (1500) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++)
                if (cq[i].size() == 0 && $urandom_range(0, 2) != 0) cq[i].push_back(rand_cmd());
        end
        wait_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: cycle %0d got no finish expected finish before 500000 ns", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dpram_arbiter.md
# dpram_arbiter

Round-robin arbiter that shares one port of a `dpram` instance between up to `REQUESTERS` clients, e.g. input logger, CPU and video readout. Each client has a valid/ack request channel and one arbitration decision is made per cycle. The arbiter drives the chosen client's command into the RAM port through a register stage. It returns read data to that client with a one-cycle `rvalid` pulse aligned to the RAM's registered output.

## Interface
- `REQUESTERS`, 4: number of clients, 2..8.
- `ADDRESS_WIDTH`, 10: RAM address width; must match the `dpram` instance.
- `DATA_WIDTH`, 8: RAM data width; must match the `dpram` instance.

Ports:
- `clk` in 1: single clock; also clocks the shared RAM port.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in REQUESTERS: bit i = client i has a command pending.
- `we` in REQUESTERS: bit i = client i command is a write.
- `addr` in REQUESTERS*ADDRESS_WIDTH: client i address in slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- `wdata` in REQUESTERS*DATA_WIDTH: client i write data, sliced the same way.
- `ack` out REQUESTERS: one-hot or zero; client i command accepted this cycle.
- `rvalid` out REQUESTERS: one-hot or zero; read data for client i is on `rdata` this cycle.
- `rdata` out DATA_WIDTH: equals `mem_q`; meaningful only while some `rvalid` bit is set.
- `mem_wren` out 1: to `dpram` `wren`.
- `mem_address` out ADDRESS_WIDTH: to `dpram` `address`.
- `mem_data` out DATA_WIDTH: to `dpram` `data`.
- `mem_q` in DATA_WIDTH: from `dpram` `q`.

## Operation
- Handshake:
  - A client holds `req`, `we`, `addr` and `wdata` stable until it sees `ack`.
  - A transfer occurs on a clock edge where `req[i]` and `ack[i]` are both 1.
  - The client may present its next command in the following cycle.
- `ack` is combinational from `req` and the round-robin pointer `last`.
  - The winner is the first set `req` bit searching upward and wrapping from `last+1`.
  - `ack` is all zero when `req` is all zero.
- On a transfer:
  - `last` takes the winner index.
  - The command registers `mem_wren`, `mem_address` and `mem_data` load the winner's `we`, `addr` and `wdata`.
  - A pipeline tag records the winner index and `is_read = ~we`.
- With no transfer, `mem_wren` is 0 in the next cycle. `mem_address` and `mem_data` hold their previous values.
- Write completion is `ack` only; no `rvalid` is produced for writes.
- Reset values:
  - `last` = REQUESTERS-1, so client 0 wins first.
  - `mem_wren`, `mem_address`, `mem_data` and `rvalid` = 0.
  - Tag valid = 0.
- Reset asserted mid-operation discards the in-flight command and its pending `rvalid`. The RAM contents are not touched.
- Starvation bound: a client holding `req` is acknowledged within REQUESTERS cycles.

## Timing
- Cycle t: `req[i]` is high and `ack[i]` is high in the same cycle. There are zero bubbles between consecutive grants.
- Cycle t+1: the `mem_*` registers present the command to the RAM port.
- Cycle t+2:
  - The RAM's `q` register holds the data, or the written data for a write.
  - For reads, `rvalid[i]` = 1 and `rdata` = `mem_q`.
- Read latency is 2 cycles from acknowledge to data. Throughput is 1 access per cycle across all clients.
- Back-to-back reads from different clients produce consecutive `rvalid` pulses in grant order.
- Write then read of the same address in consecutive grants returns the new data. The RAM write has landed before the read is issued.
- `req` deasserted without `ack` withdraws the request; this is legal.

## Structure
- Shared package or header: the arbiter-to-RAM command record (wren, address, data) and the tag width, clog2(REQUESTERS).
- Sub-module `rr_picker`: purely combinational one-hot winner selection from `req` and `last`.
- All registers, the command stage and the read-return tag pipeline live in `dpram_arbiter`.

## Test plan
- Single read: after reset, client 2 reads address 0x05 preloaded with 0xA5.
  - `ack[2]` at t.
  - `mem_address` = 0x05 at t+1.
  - `rvalid[2]` = 1 and `rdata` = 0xA5 at t+2; no other `rvalid` bit set.
- All four clients hold read `req` continuously.
  - `ack` sequence is 0,1,2,3,0,1 on consecutive cycles.
  - `rvalid` follows the same order, 2 cycles later.
- Client 1 writes 0x3C to address 0x10; in the next cycle client 0 reads 0x10.
  - `rvalid[0]` has `rdata` = 0x3C.
  - No `rvalid` pulse for the write.
- Client 3 requests alone on every cycle.
  - `ack[3]` is high every cycle.
  - `mem_wren` and `mem_address` update every cycle with no bubbles.
- Reset pulse on `reset_n` one cycle after a read `ack`.
  - No `rvalid` is produced.
  - All outputs are 0 during reset.
  - The first grant afterwards goes to client 0 when all clients request.
- Client 0 holds `req` while clients 1–3 request continuously.
  - Client 0 is acknowledged at least once every 4 cycles.
  - `ack` is never more than one-hot.
